// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/burst encodings and burst length.
// Used by the arbiter, slave and decoder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Undefined-length INCR counts as 1: it never freezes the grant.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   len = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                      len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Round-robin search: first requester after last, wrapping.
// Ports: req, last in; idx, valid out.
module ahb_rr_pick
  import ahb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [1:0]   idx,
  output logic         valid
);

  logic [3:0] req4;
  logic [1:0] cand;

  assign req4 = 4'(req);

  // Wrapping to last itself lets a lone owner keep the bus.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = 2'((int'(last) + i) % N);
      if (!valid && req4[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst/lock hold and default parking.
// Ports: hclk, hresetn, hbusreq, hlock, htrans, hburst, hready -> hgrant, hmaster, hmastlock.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [1:0]             hmaster,
  output logic                   hmastlock
);

  localparam logic [1:0] ST_ARB    = 2'd0;
  localparam logic [1:0] ST_BURST  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT =
    NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [1:0]             state, st_nxt;
  logic [3:0]             rem, rem_nxt;
  logic [1:0]             gidx, pick_idx;
  logic                   pick_vld;
  logic [3:0]             lock4, req4;
  logic                   lock_now;
  logic [NUM_MASTERS-1:0] gnt_nxt;

  assign lock4    = 4'(hlock);
  assign req4     = 4'(hbusreq);
  assign lock_now = lock4[gidx] & req4[gidx];

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant[i]) gidx = 2'(i);
    end
  end

  ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (hbusreq),
    .last  (gidx),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    rem_nxt = rem;
    if (hready) begin
      case (htrans)
        HTRANS_NONSEQ: rem_nxt = 4'(burst_len(hburst) - 5'd1);
        HTRANS_SEQ:    rem_nxt = (rem == 4'd0) ? 4'd0 : rem - 4'd1;
        HTRANS_IDLE:   rem_nxt = 4'd0;
        default:       rem_nxt = rem;
      endcase
    end
  end

  // Lock is judged on live inputs so a dropped lock re-arbitrates at once.
  always_comb begin
    st_nxt = state;
    if (hready) begin
      if (lock_now)
        st_nxt = ST_LOCKED;
      else if (rem_nxt >= 4'd2)
        st_nxt = ST_BURST;
      else
        st_nxt = ST_ARB;
    end
  end

  always_comb begin
    gnt_nxt = hgrant;
    if (hready && st_nxt == ST_ARB) begin
      gnt_nxt = pick_vld ? (NUM_MASTERS'(1) << pick_idx) : DEF_GNT;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_ARB;
      rem       <= '0;
      hgrant    <= DEF_GNT;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
    end else begin
      state  <= st_nxt;
      rem    <= rem_nxt;
      hgrant <= gnt_nxt;
      if (hready) begin
        hmaster   <= gidx;
        hmastlock <= lock4[gidx];
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus random traffic.
// Reference model tracks owner, beats left and ownership as plain integers.
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         hclk;
  logic         hresetn;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic         hmastlock;

  int total;
  int bad;

  int m_g;
  int m_hm;
  int m_ml;
  int m_rem;

  int len_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_g   = DEF;
    m_hm  = DEF;
    m_ml  = 0;
    m_rem = 0;
  endtask

  // One bus edge in terms of the rules: beats left, lock hold, rotation.
  task automatic model_edge();
    int nr;
    int ng;
    int c;
    bit locked;
    bit found;
    if (!hready) return;
    nr = m_rem;
    if (htrans == 2'b10) nr = len_tab[hburst] - 1;
    else if (htrans == 2'b11) nr = (m_rem > 0) ? m_rem - 1 : 0;
    else if (htrans == 2'b00) nr = 0;
    locked = hlock[m_g] && hbusreq[m_g];
    ng = m_g;
    if (!locked && nr <= 1) begin
      ng = DEF;
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_g + k) % N;
        if (!found && hbusreq[c]) begin
          ng = c;
          found = 1;
        end
      end
    end
    m_hm  = m_g;
    m_ml  = hlock[m_g] ? 1 : 0;
    m_g   = ng;
    m_rem = nr;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".hgrant"}, 32'(hgrant), 32'(1 << m_g));
    chk({tag, ".hmaster"}, 32'(hmaster), 32'(m_hm));
    chk({tag, ".hmastlock"}, 32'(hmastlock), 32'(m_ml));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge hclk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy);
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
  endtask

  task automatic own(input int m);
    int n;
    n = 0;
    drive(N'(1) << m, '0, 2'b00, 3'b000, 1'b1);
    while (m_g != m && n < 8) begin
      cycle("own");
      n++;
    end
    chk("own.reached", 32'(hgrant), 32'(1 << m));
  endtask

  initial begin
    int prev;
    total = 0;
    bad   = 0;
    model_reset();

    hresetn = 1'b0;
    drive('0, '0, 2'b00, 3'b000, 1'b1);
    #12;
    chk("rst.hgrant", 32'(hgrant), 32'h1);
    chk("rst.hmaster", 32'(hmaster), 32'h0);
    chk("rst.hmastlock", 32'(hmastlock), 32'h0);

    hbusreq = 4'b0100;
    #2 hresetn = 1'b1;
    cycle("req");
    chk("req.grant_m2", 32'(hgrant), 32'h4);
    cycle("req2");
    chk("req.hmaster_m2", 32'(hmaster), 32'h2);

    drive(4'b1111, '0, 2'b10, 3'b000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      prev = m_g;
      cycle("rot");
      chk("rot.step", 32'(hgrant), 32'(1 << ((prev + 1) % N)));
    end

    own(1);
    drive(4'b1010, '0, 2'b10, 3'b011, 1'b1);
    cycle("b4.n");
    chk("b4.beat1", 32'(hgrant), 32'h2);
    htrans = 2'b11;
    cycle("b4.s1");
    chk("b4.beat2", 32'(hgrant), 32'h2);
    cycle("b4.s2");
    chk("b4.beat3", 32'(hgrant), 32'h8);
    cycle("b4.s3");
    chk("b4.owner3", 32'(hmaster), 32'h3);
    htrans = 2'b00;
    hbusreq = 4'b1000;
    cycle("b4.idle");

    own(1);
    drive(4'b1010, '0, 2'b10, 3'b011, 1'b1);
    cycle("st.n");
    htrans = 2'b11;
    hready = 1'b0;
    cycle("st.w1");
    chk("st.wait1", 32'(hgrant), 32'h2);
    cycle("st.w2");
    chk("st.wait2", 32'(hgrant), 32'h2);
    hready = 1'b1;
    cycle("st.s1");
    chk("st.beat2", 32'(hgrant), 32'h2);
    cycle("st.s2");
    chk("st.beat3", 32'(hgrant), 32'h8);
    cycle("st.s3");
    chk("st.owner3", 32'(hmaster), 32'h3);

    own(0);
    drive(4'b0011, 4'b0001, 2'b10, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle("lk");
      chk("lk.hold", 32'(hgrant), 32'h1);
      chk("lk.mastlock", 32'(hmastlock), 32'h1);
    end
    hlock = '0;
    htrans = 2'b00;
    cycle("lk.drop");
    chk("lk.m1", 32'(hgrant), 32'h2);

    drive(4'b0110, '0, 2'b10, 3'b101, 1'b1);
    cycle("b8.n");
    htrans = 2'b11;
    cycle("b8.s1");
    cycle("b8.s2");
    chk("b8.hold", 32'(hgrant), 32'h2);
    htrans = 2'b00;
    cycle("b8.idle");
    chk("b8.to_m2", 32'(hgrant), 32'h4);

    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
            2'($urandom), 3'($urandom), $urandom_range(0, 4) != 0);
      cycle("rnd");
    end

    own(2);
    drive(4'b1011, '0, 2'b10, 3'b111, 1'b1);
    cycle("rb.n");
    htrans = 2'b11;
    cycle("rb.s1");
    hready = 1'b0;
    #2 hresetn = 1'b0;
    #1;
    model_reset();
    check_model("rb.async");
    #1 hresetn = 1'b1;
    hready = 1'b1;
    htrans = 2'b00;
    cycle("rb.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
